w_stage_reg: RTL and testbench

W_STAGE_REG -- requirements
Module: w_stage_reg

---
 rtl/w_stage_reg.sv | 154 +++++++++++++++
 tb/tb_w_stage_reg.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/w_stage_reg.sv
// ---------------------------------------------------------------------------
// w_stage_reg -- writeback-stage pipeline register
//
// Captures the memory-stage results at the end of each cycle and presents
// them to the writeback stage. The register can hold its contents (stall),
// be replaced by a NOP bubble, or be frozen after an instruction with a
// non-AOK status reaches writeback. Once frozen, only reset releases it.
//
// Per clock edge, the highest-priority case wins:
//   reset > frozen hold > stall hold > bubble > load
//
// Optional feature macro: W_STAGE_RETIRE_CNT_EN
//   When defined, adds the W_retire_cnt output. It is a 32-bit count of
//   loaded instructions whose icode is not NOP. The count wraps to zero.
//
// Ports
//   clk           in   sole clock, rising-edge active
//   rst           in   synchronous active-high reset
//   W_stall       in   hold current contents
//   W_bubble      in   load a NOP bubble instead of upstream values
//   m_stat        in   [STAT_W-1:0]  memory-stage status
//   m_icode       in   [3:0]         memory-stage instruction code
//   m_valE        in   [DATA_W-1:0]  memory-stage ALU result
//   m_valM        in   [DATA_W-1:0]  memory-stage memory read value
//   m_dstE        in   [REG_W-1:0]   destination register for valE
//   m_dstM        in   [REG_W-1:0]   destination register for valM
//   W_stat .. W_dstM  out  registered copies of the m_* fields
//   W_frozen      out  high while the stage is frozen
//   W_retire_cnt  out  [31:0] retired-instruction count (macro only)
// ---------------------------------------------------------------------------
module w_stage_reg #(
    parameter int                DATA_W    = 64,
    parameter int                REG_W     = 4,
    parameter int                STAT_W    = 2,
    parameter logic [3:0]        NOP_ICODE = 4'h1,
    parameter logic [REG_W-1:0]  RNONE     = {REG_W{1'b1}},
    parameter logic [STAT_W-1:0] STAT_AOK  = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              W_stall,
    input  logic              W_bubble,
    input  logic [STAT_W-1:0] m_stat,
    input  logic [3:0]        m_icode,
    input  logic [DATA_W-1:0] m_valE,
    input  logic [DATA_W-1:0] m_valM,
    input  logic [REG_W-1:0]  m_dstE,
    input  logic [REG_W-1:0]  m_dstM,
    output logic [STAT_W-1:0] W_stat,
    output logic [3:0]        W_icode,
    output logic [DATA_W-1:0] W_valE,
    output logic [DATA_W-1:0] W_valM,
    output logic [REG_W-1:0]  W_dstE,
    output logic [REG_W-1:0]  W_dstM,
    output logic              W_frozen
`ifdef W_STAGE_RETIRE_CNT_EN
    ,
    output logic [31:0]       W_retire_cnt
`endif
);

    typedef enum logic {
        RUN    = 1'b0,
        FROZEN = 1'b1
    } state_t;

    state_t state;
    state_t state_next;

    logic load_en;
    logic bubble_en;

    // Decide what this edge does to the datapath. While frozen, and while
    // stalled, neither strobe fires, so the registers keep their contents.
    // A stall also masks the bubble request when both arrive together.
    always_comb begin
        load_en   = 1'b0;
        bubble_en = 1'b0;
        if (state == RUN && !W_stall) begin
            if (W_bubble) begin
                bubble_en = 1'b1;
            end else begin
                load_en = 1'b1;
            end
        end
    end

    // Next-state logic. The stage freezes on the same edge that loads a
    // non-AOK status, so the faulting status stays visible in W_stat. A
    // bubble carries AOK and a stall loads nothing, so neither can freeze
    // the stage. Leaving FROZEN is handled only by the reset in the state
    // register.
    always_comb begin
        state_next = state;
        if (load_en && (m_stat != STAT_AOK)) begin
            state_next = FROZEN;
        end
    end

    // State register. Reset takes priority over everything, including FROZEN.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // Datapath registers. Reset and bubble load the same NOP pattern. Reset
    // drops whatever upstream value is presented in that cycle. Any case
    // not listed here (frozen or stalled) keeps the current contents.
    always_ff @(posedge clk) begin
        if (rst) begin
            W_stat  <= STAT_AOK;
            W_icode <= NOP_ICODE;
            W_valE  <= '0;
            W_valM  <= '0;
            W_dstE  <= RNONE;
            W_dstM  <= RNONE;
        end else if (bubble_en) begin
            W_stat  <= STAT_AOK;
            W_icode <= NOP_ICODE;
            W_valE  <= '0;
            W_valM  <= '0;
            W_dstE  <= RNONE;
            W_dstM  <= RNONE;
        end else if (load_en) begin
            W_stat  <= m_stat;
            W_icode <= m_icode;
            W_valE  <= m_valE;
            W_valM  <= m_valM;
            W_dstE  <= m_dstE;
            W_dstM  <= m_dstM;
        end
    end

    // W_frozen is decoded straight from the state flop, so it stays a
    // registered output with no path from any input.
    assign W_frozen = (state == FROZEN);

`ifdef W_STAGE_RETIRE_CNT_EN
    // Retired-instruction counter. It advances only on a real load of a
    // non-NOP icode. Stalls, bubbles and the frozen state leave it
    // unchanged. It wraps naturally at 32 bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            W_retire_cnt <= 32'd0;
        end else if (load_en && (m_icode != NOP_ICODE)) begin
            W_retire_cnt <= W_retire_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_w_stage_reg.sv
// ---------------------------------------------------------------------------
// tb_w_stage_reg -- directed self-checking bench for w_stage_reg
//
// Each task drives one scenario and checks the registered outputs one
// nanosecond after the rising edge. Expected values are written out by hand.
// When W_STAGE_RETIRE_CNT_EN is defined, the retire counter is also checked
// against a count that the bench keeps itself.
// ---------------------------------------------------------------------------
module tb_w_stage_reg;

    logic        clk;
    logic        rst;
    logic        W_stall;
    logic        W_bubble;
    logic [1:0]  m_stat;
    logic [3:0]  m_icode;
    logic [63:0] m_valE;
    logic [63:0] m_valM;
    logic [3:0]  m_dstE;
    logic [3:0]  m_dstM;
    logic [1:0]  W_stat;
    logic [3:0]  W_icode;
    logic [63:0] W_valE;
    logic [63:0] W_valM;
    logic [3:0]  W_dstE;
    logic [3:0]  W_dstM;
    logic        W_frozen;
`ifdef W_STAGE_RETIRE_CNT_EN
    logic [31:0] W_retire_cnt;
    logic [31:0] exp_cnt;
`endif

    int pass_cnt;
    int total_cnt;

    // All datapath outputs packed together: stat, icode, valE, valM, dstE, dstM.
    logic [141:0] w_all;
    assign w_all = {W_stat, W_icode, W_valE, W_valM, W_dstE, W_dstM};

    // The NOP pattern that reset and bubble both produce.
    localparam logic [141:0] NOP_ALL = {2'd0, 4'h1, 64'd0, 64'd0, 4'hF, 4'hF};

    w_stage_reg dut (
        .clk      (clk),
        .rst      (rst),
        .W_stall  (W_stall),
        .W_bubble (W_bubble),
        .m_stat   (m_stat),
        .m_icode  (m_icode),
        .m_valE   (m_valE),
        .m_valM   (m_valM),
        .m_dstE   (m_dstE),
        .m_dstM   (m_dstM),
        .W_stat   (W_stat),
        .W_icode  (W_icode),
        .W_valE   (W_valE),
        .W_valM   (W_valM),
        .W_dstE   (W_dstE),
        .W_dstM   (W_dstM),
        .W_frozen (W_frozen)
`ifdef W_STAGE_RETIRE_CNT_EN
        ,
        .W_retire_cnt (W_retire_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] st, input logic [3:0] ic,
                         input logic [63:0] ve, input logic [63:0] vm,
                         input logic [3:0] de, input logic [3:0] dm);
        m_stat  = st;
        m_icode = ic;
        m_valE  = ve;
        m_valM  = vm;
        m_dstE  = de;
        m_dstM  = dm;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        W_stall = 1'b1;
        W_bubble = 1'b1;
        drive(2'd3, 4'h9, 64'hAAAA_AAAA_AAAA_AAAA, 64'h5555, 4'h3, 4'h4);
        tick();
        total_cnt++;
        if (w_all !== NOP_ALL) $display("[TB] FAIL reset_fields: got %h expected %h", w_all, NOP_ALL);
        else pass_cnt++;
        total_cnt++;
        if (W_frozen !== 1'b0) $display("[TB] FAIL reset_frozen: got %b expected 0", W_frozen);
        else pass_cnt++;
`ifdef W_STAGE_RETIRE_CNT_EN
        exp_cnt = 32'd0;
        total_cnt++;
        if (W_retire_cnt !== exp_cnt) $display("[TB] FAIL reset_cnt: got %h expected %h", W_retire_cnt, exp_cnt);
        else pass_cnt++;
`endif
        rst = 1'b0;
        W_stall = 1'b0;
        W_bubble = 1'b0;
    endtask

    task automatic test_load();
        drive(2'd0, 4'h3, 64'h1234, 64'hDEAD_BEEF_CAFE_F00D, 4'h2, 4'h5);
        tick();
        total_cnt++;
        if (w_all !== {2'd0, 4'h3, 64'h1234, 64'hDEAD_BEEF_CAFE_F00D, 4'h2, 4'h5})
            $display("[TB] FAIL load_basic: got %h", w_all);
        else pass_cnt++;
`ifdef W_STAGE_RETIRE_CNT_EN
        exp_cnt = 32'd1;
        total_cnt++;
        if (W_retire_cnt !== exp_cnt) $display("[TB] FAIL load_cnt: got %h expected %h", W_retire_cnt, exp_cnt);
        else pass_cnt++;
`endif
        // Full-width patterns to catch truncation or sign extension.
        drive(2'd0, 4'hF, 64'h8000_0000_0000_0001, 64'hFFFF_FFFF_FFFF_FFFE, 4'hE, 4'h0);
        tick();
        total_cnt++;
        if (w_all !== {2'd0, 4'hF, 64'h8000_0000_0000_0001, 64'hFFFF_FFFF_FFFF_FFFE, 4'hE, 4'h0})
            $display("[TB] FAIL load_wide: got %h", w_all);
        else pass_cnt++;
        total_cnt++;
        if (W_frozen !== 1'b0) $display("[TB] FAIL load_frozen: got %b expected 0", W_frozen);
        else pass_cnt++;
`ifdef W_STAGE_RETIRE_CNT_EN
        exp_cnt = 32'd2;
`endif
    endtask

    task automatic test_stall();
        // At this point the register holds the wide vector from test_load.
        W_stall = 1'b1;
        W_bubble = 1'b1;
        drive(2'd0, 4'h6, 64'h1, 64'h2, 4'h7, 4'h8);
        tick();
        tick();
        total_cnt++;
        if (w_all !== {2'd0, 4'hF, 64'h8000_0000_0000_0001, 64'hFFFF_FFFF_FFFF_FFFE, 4'hE, 4'h0})
            $display("[TB] FAIL stall_and_bubble_hold: got %h", w_all);
        else pass_cnt++;
        W_bubble = 1'b0;
        drive(2'd2, 4'h6, 64'h1, 64'h2, 4'h7, 4'h8);
        tick();
        total_cnt++;
        if (w_all !== {2'd0, 4'hF, 64'h8000_0000_0000_0001, 64'hFFFF_FFFF_FFFF_FFFE, 4'hE, 4'h0})
            $display("[TB] FAIL stall_hold: got %h", w_all);
        else pass_cnt++;
        total_cnt++;
        if (W_frozen !== 1'b0) $display("[TB] FAIL stall_no_freeze: got %b expected 0", W_frozen);
        else pass_cnt++;
`ifdef W_STAGE_RETIRE_CNT_EN
        total_cnt++;
        if (W_retire_cnt !== exp_cnt) $display("[TB] FAIL stall_cnt: got %h expected %h", W_retire_cnt, exp_cnt);
        else pass_cnt++;
`endif
        W_stall = 1'b0;
    endtask

    task automatic test_bubble();
        W_bubble = 1'b1;
        drive(2'd2, 4'h5, 64'h77, 64'h99, 4'h6, 4'h7);
        tick();
        total_cnt++;
        if (w_all !== NOP_ALL) $display("[TB] FAIL bubble_fields: got %h expected %h", w_all, NOP_ALL);
        else pass_cnt++;
        total_cnt++;
        if (W_frozen !== 1'b0) $display("[TB] FAIL bubble_no_freeze: got %b expected 0", W_frozen);
        else pass_cnt++;
`ifdef W_STAGE_RETIRE_CNT_EN
        total_cnt++;
        if (W_retire_cnt !== exp_cnt) $display("[TB] FAIL bubble_cnt: got %h expected %h", W_retire_cnt, exp_cnt);
        else pass_cnt++;
`endif
        W_bubble = 1'b0;
    endtask

    task automatic test_back_to_back();
        drive(2'd0, 4'h2, 64'h11, 64'h22, 4'h1, 4'h2);
        tick();
        total_cnt++;
        if (w_all !== {2'd0, 4'h2, 64'h11, 64'h22, 4'h1, 4'h2}) $display("[TB] FAIL b2b_0: got %h", w_all);
        else pass_cnt++;
        // A NOP icode loaded without a bubble still passes through the stage.
        drive(2'd0, 4'h1, 64'h33, 64'h44, 4'h3, 4'h4);
        tick();
        total_cnt++;
        if (w_all !== {2'd0, 4'h1, 64'h33, 64'h44, 4'h3, 4'h4}) $display("[TB] FAIL b2b_1: got %h", w_all);
        else pass_cnt++;
        drive(2'd0, 4'h8, 64'h55, 64'h66, 4'h5, 4'h6);
        tick();
        total_cnt++;
        if (w_all !== {2'd0, 4'h8, 64'h55, 64'h66, 4'h5, 4'h6}) $display("[TB] FAIL b2b_2: got %h", w_all);
        else pass_cnt++;
`ifdef W_STAGE_RETIRE_CNT_EN
        exp_cnt = exp_cnt + 32'd2;
        total_cnt++;
        if (W_retire_cnt !== exp_cnt) $display("[TB] FAIL b2b_cnt: got %h expected %h", W_retire_cnt, exp_cnt);
        else pass_cnt++;
`endif
    endtask

    task automatic test_freeze();
        drive(2'd2, 4'h7, 64'hABCD, 64'hEF01, 4'h9, 4'hA);
        tick();
        total_cnt++;
        if (w_all !== {2'd2, 4'h7, 64'hABCD, 64'hEF01, 4'h9, 4'hA}) $display("[TB] FAIL freeze_load: got %h", w_all);
        else pass_cnt++;
        total_cnt++;
        if (W_frozen !== 1'b1) $display("[TB] FAIL freeze_enter: got %b expected 1", W_frozen);
        else pass_cnt++;
`ifdef W_STAGE_RETIRE_CNT_EN
        exp_cnt = exp_cnt + 32'd1;
`endif
        // While frozen, a plain load, a bubble and a stall must all be ignored.
        for (int i = 0; i < 3; i++) begin
            drive(2'd0, 4'h3, 64'h4242, 64'h4343, 4'h1, 4'h2);
            W_bubble = (i == 1);
            W_stall  = (i == 2);
            tick();
            total_cnt++;
            if (w_all !== {2'd2, 4'h7, 64'hABCD, 64'hEF01, 4'h9, 4'hA} || W_frozen !== 1'b1)
                $display("[TB] FAIL freeze_hold_%0d: got %h frozen %b", i, w_all, W_frozen);
            else pass_cnt++;
        end
        W_bubble = 1'b0;
        W_stall = 1'b0;
`ifdef W_STAGE_RETIRE_CNT_EN
        total_cnt++;
        if (W_retire_cnt !== exp_cnt) $display("[TB] FAIL freeze_cnt: got %h expected %h", W_retire_cnt, exp_cnt);
        else pass_cnt++;
`endif
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total_cnt++;
        if (w_all !== NOP_ALL || W_frozen !== 1'b0)
            $display("[TB] FAIL freeze_reset: got %h frozen %b expected %h frozen 0", w_all, W_frozen, NOP_ALL);
        else pass_cnt++;
`ifdef W_STAGE_RETIRE_CNT_EN
        exp_cnt = 32'd0;
`endif
    endtask

    task automatic test_reset_midstream();
        drive(2'd0, 4'hC, 64'h1111, 64'h2222, 4'h3, 4'h4);
        tick();
        // The value presented alongside reset is discarded.
        rst = 1'b1;
        drive(2'd0, 4'hD, 64'h9999, 64'h8888, 4'h5, 4'h6);
        tick();
        total_cnt++;
        if (w_all !== NOP_ALL) $display("[TB] FAIL midreset_discard: got %h expected %h", w_all, NOP_ALL);
        else pass_cnt++;
        rst = 1'b0;
        drive(2'd0, 4'hB, 64'h7777, 64'h6666, 4'h7, 4'h8);
        tick();
        total_cnt++;
        if (w_all !== {2'd0, 4'hB, 64'h7777, 64'h6666, 4'h7, 4'h8}) $display("[TB] FAIL midreset_first_load: got %h", w_all);
        else pass_cnt++;
`ifdef W_STAGE_RETIRE_CNT_EN
        exp_cnt = 32'd1;
        total_cnt++;
        if (W_retire_cnt !== exp_cnt) $display("[TB] FAIL midreset_cnt: got %h expected %h", W_retire_cnt, exp_cnt);
        else pass_cnt++;
`endif
    endtask

    initial begin
        pass_cnt = 0;
        total_cnt = 0;
        rst = 1'b1;
        W_stall = 1'b0;
        W_bubble = 1'b0;
        drive(2'd0, 4'h0, 64'd0, 64'd0, 4'h0, 4'h0);
        $display("[TB] starting w_stage_reg directed tests");
        test_reset();
        test_load();
        test_stall();
        test_bubble();
        test_back_to_back();
        test_freeze();
        test_reset_midstream();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
